// File: rtl/soc_system_cpu_ram_pkg.sv
// Shared constants, state encoding and helpers for the CPU on-chip RAM burst adapter.
package soc_system_cpu_ram_pkg;

   localparam int unsigned ADDR_W         = 14;
   localparam int unsigned DEPTH          = 15000;
   localparam int unsigned BURST_W        = 4;
   localparam int unsigned RAM_RD_LATENCY = 1;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   // A burstcount of zero is handled as a single beat.
   function automatic logic [BURST_W-1:0] eff_count(input logic [BURST_W-1:0] cnt);
      return (cnt == '0) ? BURST_W'(1) : cnt;
   endfunction

endpackage

// File: rtl/soc_system_cpu_ram_addr_gen.sv
// Beat address generator: start/count capture, beat counter, last-beat flag and depth check.
// Wrapping bursts are built only when CPU_RAM_BURST_WRAP_EN is defined.
module soc_system_cpu_ram_addr_gen
   import soc_system_cpu_ram_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               advance,
   input  logic [ADDR_W-1:0]  start_addr,
   input  logic [BURST_W-1:0] burstcount,
   output logic [ADDR_W-1:0]  beat_addr,
   output logic               last_beat,
   output logic               out_of_range
);

   logic [ADDR_W-1:0]  start_q;
   logic [BURST_W-1:0] count_q;
   logic [BURST_W-1:0] idx_q;
   logic [ADDR_W-1:0]  cur_start;
   logic [BURST_W-1:0] cur_count;
   logic [BURST_W-1:0] cur_idx;
   logic [ADDR_W-1:0]  linear_addr;

   // Beat 0 is issued in the acceptance cycle, so the live command bypasses the registers.
   always_comb begin
      cur_start = load ? start_addr : start_q;
      cur_count = load ? eff_count(burstcount) : count_q;
      cur_idx   = load ? '0 : idx_q;
   end

   assign linear_addr = cur_start + ADDR_W'(cur_idx);

`ifdef CPU_RAM_BURST_WRAP_EN
   logic [ADDR_W-1:0] wrap_mask;
   logic              count_pow2;

   assign wrap_mask  = ADDR_W'(cur_count) - ADDR_W'(1);
   assign count_pow2 = ((cur_count & (cur_count - BURST_W'(1))) == '0);
   assign beat_addr  = count_pow2 ? ((cur_start & ~wrap_mask) | (linear_addr & wrap_mask))
                                  : linear_addr;
`else
   assign beat_addr = linear_addr;
`endif

   assign last_beat    = (cur_idx == (cur_count - BURST_W'(1)));
   assign out_of_range = (beat_addr >= ADDR_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q <= '0;
         count_q <= BURST_W'(1);
         idx_q   <= '0;
      end else begin
         if (load) begin
            start_q <= start_addr;
            count_q <= eff_count(burstcount);
         end
         if (advance) begin
            idx_q <= cur_idx + BURST_W'(1);
         end
      end
   end

endmodule

// File: rtl/soc_system_cpu_ram_burst_adapter.sv
// Avalon-MM burst to single-beat adapter in front of the 15000-word CPU RAM.
// Optional wrapping bursts via CPU_RAM_BURST_WRAP_EN (handled in the address generator).
module soc_system_cpu_ram_burst_adapter
   import soc_system_cpu_ram_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  s_address,
   input  logic [BURST_W-1:0] s_burstcount,
   input  logic [3:0]         s_byteenable,
   input  logic               s_read,
   input  logic               s_write,
   input  logic [31:0]        s_writedata,
   output logic               s_waitrequest,
   output logic [31:0]        s_readdata,
   output logic               s_readdatavalid,
   output logic [ADDR_W-1:0]  m_address,
   output logic [3:0]         m_byteenable,
   output logic               m_chipselect,
   output logic               m_write,
   output logic [31:0]        m_writedata,
   input  logic [31:0]        m_readdata,
   output logic               oob_err
);

   state_t                    state_q, state_d;
   logic                      accept;
   logic                      issue;
   logic                      issue_wr;
   logic                      collision;
   logic [ADDR_W-1:0]         beat_addr;
   logic                      last_beat;
   logic                      beat_oob;
   logic [RAM_RD_LATENCY-1:0] rd_valid_q;
   logic [RAM_RD_LATENCY-1:0] rd_oob_q;
   logic                      oob_err_q;

   soc_system_cpu_ram_addr_gen u_addr_gen (
      .clk          (clk),
      .reset        (reset),
      .load         (accept),
      .advance      (issue),
      .start_addr   (s_address),
      .burstcount   (s_burstcount),
      .beat_addr    (beat_addr),
      .last_beat    (last_beat),
      .out_of_range (beat_oob)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept && !last_beat) begin
               state_d = s_write ? WR_BURST : RD_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (issue && last_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Issue is also gated by reset so nothing reaches the RAM in the reset cycle.
   always_comb begin
      accept   = 1'b0;
      issue    = 1'b0;
      issue_wr = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept   = (s_read | s_write) & ~reset;
            issue    = accept;
            issue_wr = s_write;
         end
         RD_BURST: begin
            issue = ~reset;
         end
         WR_BURST: begin
            issue    = s_write & ~reset;
            issue_wr = 1'b1;
         end
         default: ;
      endcase
      collision       = accept & s_read & s_write;
      s_waitrequest   = (state_q == RD_BURST) & ~reset;
      m_chipselect    = issue & ~beat_oob;
      m_write         = issue & issue_wr & ~beat_oob;
      m_address       = issue ? beat_addr : '0;
      m_byteenable    = issue_wr ? s_byteenable : 4'hF;
      m_writedata     = s_writedata;
      s_readdatavalid = rd_valid_q[RAM_RD_LATENCY-1] & ~reset;
      s_readdata      = (s_readdatavalid && !rd_oob_q[RAM_RD_LATENCY-1]) ? m_readdata : '0;
      oob_err         = oob_err_q;
   end

   // Out-of-range read beats still return a (zero) beat to keep the burst length intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= '0;
         rd_oob_q   <= '0;
         oob_err_q  <= 1'b0;
      end else begin
         rd_valid_q <= RAM_RD_LATENCY'({rd_valid_q, issue & ~issue_wr});
         rd_oob_q   <= RAM_RD_LATENCY'({rd_oob_q, beat_oob});
         oob_err_q  <= oob_err_q | (issue & beat_oob) | collision;
      end
   end

endmodule

// File: tb/tb_soc_system_cpu_ram_burst_adapter.sv
// Self-checking bench for the CPU RAM burst adapter with a behavioural RAM and shadow memory.
module tb_soc_system_cpu_ram_burst_adapter;
   import soc_system_cpu_ram_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [ADDR_W-1:0]  s_address;
   logic [BURST_W-1:0] s_burstcount;
   logic [3:0]         s_byteenable;
   logic               s_read;
   logic               s_write;
   logic [31:0]        s_writedata;
   logic               s_waitrequest;
   logic [31:0]        s_readdata;
   logic               s_readdatavalid;
   logic [ADDR_W-1:0]  m_address;
   logic [3:0]         m_byteenable;
   logic               m_chipselect;
   logic               m_write;
   logic [31:0]        m_writedata;
   logic [31:0]        m_readdata;
   logic               oob_err;

   always #5 clk = ~clk;

   soc_system_cpu_ram_burst_adapter dut (
      .clk             (clk),
      .reset           (reset),
      .s_address       (s_address),
      .s_burstcount    (s_burstcount),
      .s_byteenable    (s_byteenable),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_address       (m_address),
      .m_byteenable    (m_byteenable),
      .m_chipselect    (m_chipselect),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_readdata      (m_readdata),
      .oob_err         (oob_err)
   );

   function automatic logic [31:0] seed_word(input int unsigned a);
      return 32'hA5A5_0000 ^ (a * 32'd2654435761);
   endfunction

   // RAM with registered address and unregistered q; reloads a known pattern on reset.
   logic [31:0]       ram [0:16383];
   logic [ADDR_W-1:0] ram_addr_q;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16384; i++) ram[i] <= seed_word(i);
      end else if (m_chipselect && m_write) begin
         for (int b = 0; b < 4; b++) begin
            if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
         end
      end
      ram_addr_q <= m_address;
   end

   assign m_readdata = ram[ram_addr_q];

   logic [31:0] exp_mem [0:16383];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic        pend_v;
   logic [31:0] pend_d;
   logic        exp_oob;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic init_exp_mem();
      for (int i = 0; i < 16384; i++) exp_mem[i] = seed_word(i);
   endtask

   // Address of beat i straight from the burst rules.
   function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] start,
                                                    input logic [BURST_W-1:0] cnt,
                                                    input int unsigned i);
`ifdef CPU_RAM_BURST_WRAP_EN
      int unsigned n;
      n = (cnt == '0) ? 1 : 32'(cnt);
      if ((n & (n - 1)) == 0)
         return ADDR_W'((32'(start) & ~(n - 1)) | ((32'(start) + i) & (n - 1)));
`endif
      return ADDR_W'(32'(start) + i);
   endfunction

   // Called just after the inputs for a cycle are driven; ends on the next falling edge.
   task automatic cycle(input string tag, input logic exp_cs, input logic exp_we,
                        input logic addr_chk, input logic [ADDR_W-1:0] exp_addr,
                        input logic exp_wait, input logic rd_issue, input logic [31:0] rd_data,
                        input logic oob_evt);
      #2;
      check({tag, ":wait"}, 32'(s_waitrequest), 32'(exp_wait));
      check({tag, ":cs"}, 32'(m_chipselect), 32'(exp_cs));
      check({tag, ":we"}, 32'(m_write), 32'(exp_we));
      if (addr_chk) check({tag, ":addr"}, 32'(m_address), 32'(exp_addr));
      check({tag, ":rdv"}, 32'(s_readdatavalid), 32'(pend_v));
      if (pend_v) check({tag, ":rdata"}, s_readdata, pend_d);
      check({tag, ":oob"}, 32'(oob_err), 32'(exp_oob));
      pend_v  = rd_issue;
      pend_d  = rd_data;
      exp_oob = exp_oob | oob_evt;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         s_read  = 1'b0;
         s_write = 1'b0;
         cycle("idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic rd_burst(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] cnt,
                           input int stop_after);
      int unsigned       n;
      logic [ADDR_W-1:0] a;
      logic              oob;
      n = (cnt == '0) ? 1 : 32'(cnt);
      for (int i = 0; i < n && i < stop_after; i++) begin
         a   = model_addr(addr, cnt, i);
         oob = (32'(a) >= DEPTH);
         s_write      = 1'b0;
         s_read       = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         s_address    = (i == 0) ? addr : ADDR_W'($urandom);
         s_burstcount = cnt;
         cycle("rd", ~oob, 1'b0, 1'b1, a, i != 0, 1'b1, oob ? 32'h0 : exp_mem[a], oob);
      end
      s_read = 1'b0;
   endtask

   task automatic wr_burst(input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] cnt,
                           input int gap_after, input int gap_len, input logic with_read);
      int unsigned       n;
      logic [ADDR_W-1:0] a;
      logic              oob;
      logic [31:0]       d;
      logic [3:0]        be;
      n = (cnt == '0) ? 1 : 32'(cnt);
      for (int i = 0; i < n; i++) begin
         a   = model_addr(addr, cnt, i);
         oob = (32'(a) >= DEPTH);
         d   = $urandom;
         be  = 4'($urandom);
         s_write      = 1'b1;
         s_read       = (i == 0) ? with_read : 1'($urandom_range(0, 1));
         s_address    = (i == 0) ? addr : ADDR_W'($urandom);
         s_burstcount = cnt;
         s_writedata  = d;
         s_byteenable = be;
         cycle("wr", ~oob, ~oob, 1'b1, a, 1'b0, 1'b0, '0, oob | ((i == 0) & with_read));
         if (!oob) begin
            for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
         end
         if (i == gap_after && i != n - 1) begin
            for (int g = 0; g < gap_len; g++) begin
               s_write     = 1'b0;
               s_read      = 1'($urandom_range(0, 1));
               s_writedata = $urandom;
               cycle("wr_gap", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            end
         end
      end
      s_write = 1'b0;
      s_read  = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ":wait"}, 32'(s_waitrequest), 32'h0);
      check({tag, ":rdv"}, 32'(s_readdatavalid), 32'h0);
      check({tag, ":rdata"}, s_readdata, 32'h0);
      check({tag, ":cs"}, 32'(m_chipselect), 32'h0);
      check({tag, ":we"}, 32'(m_write), 32'h0);
      check({tag, ":addr"}, 32'(m_address), 32'h0);
      check({tag, ":oob"}, 32'(oob_err), 32'h0);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_read  = 1'b0;
      s_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      pend_v  = 1'b0;
      exp_oob = 1'b0;
      init_exp_mem();
   endtask

   logic [ADDR_W-1:0]  r_addr;
   logic [BURST_W-1:0] r_cnt;

   initial begin
      reset        = 1'b1;
      s_address    = '0;
      s_burstcount = '0;
      s_byteenable = 4'h0;
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_writedata  = '0;
      pend_v       = 1'b0;
      pend_d       = '0;
      exp_oob      = 1'b0;
      init_exp_mem();

      @(negedge clk);
      #2 check_reset_vals("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      #2 check_reset_vals("rst_release");
      @(negedge clk);

      // Linear read of four beats, then a write with a two-cycle gap read back.
      rd_burst(14'h010, 4'd4, 99);
      idle(1);
      wr_burst(14'h100, 4'd3, 1, 2, 1'b0);
      rd_burst(14'h100, 4'd3, 99);
      idle(1);

      // Wrap candidate, zero burstcount, and back-to-back commands.
      rd_burst(14'h006, 4'd4, 99);
      wr_burst(14'h00B, 4'd8, 3, 1, 1'b0);
      rd_burst(14'h008, 4'd8, 99);
      rd_burst(14'h030, 4'd0, 99);
      wr_burst(14'h031, 4'd2, 0, 0, 1'b0);
      rd_burst(14'h030, 4'd3, 99);
      idle(1);

      for (int t = 0; t < 40; t++) begin
         r_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 63))
                                               : ADDR_W'($urandom_range(0, 14980));
         r_cnt  = BURST_W'($urandom_range(0, 8));
         if ($urandom_range(0, 1) == 1) rd_burst(r_addr, r_cnt, 99);
         else wr_burst(r_addr, r_cnt, $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);

      // Top-of-memory boundary.
      rd_burst(14'd14999, 4'd2, 99);
      rd_burst(14'd14998, 4'd3, 99);
      wr_burst(14'd14999, 4'd2, 0, 0, 1'b0);
      rd_burst(14'd14999, 4'd1, 99);
      idle(2);

      // Read and write together: only the write happens.
      do_reset();
      idle(1);
      wr_burst(14'h020, 4'd1, 0, 0, 1'b1);
      rd_burst(14'h020, 4'd1, 99);
      idle(2);

      // Reset in the middle of an eight-beat read.
      do_reset();
      idle(1);
      rd_burst(14'h200, 4'd8, 3);
      reset  = 1'b1;
      s_read = 1'b0;
      #2;
      check("rst_mid_hold:rdv", 32'(s_readdatavalid), 32'h0);
      check("rst_mid_hold:cs", 32'(m_chipselect), 32'h0);
      @(negedge clk);
      reset   = 1'b0;
      pend_v  = 1'b0;
      exp_oob = 1'b0;
      init_exp_mem();
      #2 check_reset_vals("rst_mid");
      @(negedge clk);
      idle(3);
      rd_burst(14'h200, 4'd2, 99);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
